laser_target_core: RTL and testbench

Parametrised two-player laser-target game core. It debounces each player's flex trigger, drives that player's laser for a fixed shot window, and detects hits on the player's current target photodiode. It keeps a BCD score per player, moves the target after every hit, and drives four seven-segment digits. It sits between the raw sensor and actuator pins and the board top level, and generalises the fixed-target decode stage into a working game.

---
 rtl/laser_game_pkg.sv | 41 ++++
 rtl/laser_player.sv | 144 ++++++++++++++
 rtl/laser_target_core.sv | 129 ++++++++++++
 tb/tb_laser_target_core.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_game_pkg.sv
// Shared types and constants for the two-player laser-target game core.
// Optional build macro MISS_PENALTY_EN (see laser_player) changes miss scoring.
package laser_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_COOLDOWN,
        ST_REARM
    } player_state_t;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left into bit 0.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [7:0] lfsr_step(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/laser_player.sv
// One player: trigger synchroniser + debouncer, shot FSM and saturating BCD score.
// With MISS_PENALTY_EN defined, a shot timeout decrements the score (floor 00).
module laser_player
    import laser_game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SHOT_CYCLES     = 64,
    parameter int COOLDOWN_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flex,
    input  logic       photo_hit,
    output logic       laser,
    output logic       hit,
    output logic [3:0] tens_next,
    output logic [3:0] ones_next
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TMR_MAX = (SHOT_CYCLES > COOLDOWN_CYCLES) ? SHOT_CYCLES : COOLDOWN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SHOT_LAST = TMR_W'(SHOT_CYCLES - 1);
    localparam logic [TMR_W-1:0] COOL_LAST = TMR_W'(COOLDOWN_CYCLES - 1);

    logic             flex_p0;
    logic             flex_p1;
    logic             flex_deb;
    logic             flex_deb_q;
    logic [DEB_W-1:0] deb_cnt;

    player_state_t    state;
    logic [TMR_W-1:0] timer;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             miss;
    logic             trig_rise;

    // Stage p0/p1: metastability filter; then the debounced level only flips
    // after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            flex_p0    <= 1'b0;
            flex_p1    <= 1'b0;
            flex_deb   <= 1'b0;
            flex_deb_q <= 1'b0;
            deb_cnt    <= '0;
        end else begin
            flex_p0    <= flex;
            flex_p1    <= flex_p0;
            flex_deb_q <= flex_deb;
            if (flex_p1 != flex_deb) begin
                if (deb_cnt == DEB_LAST) begin
                    flex_deb <= flex_p1;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign trig_rise = flex_deb & ~flex_deb_q;
    assign hit       = (state == ST_FIRE) && photo_hit;
    assign miss      = (state == ST_FIRE) && !photo_hit && (timer == SHOT_LAST);

    always_comb begin
        tens_next = tens;
        ones_next = ones;
        if (hit) begin
            if (ones != 4'd9) begin
                ones_next = ones + 4'd1;
            end else if (tens != 4'd9) begin
                ones_next = 4'd0;
                tens_next = tens + 4'd1;
            end
        end
`ifdef MISS_PENALTY_EN
        else if (miss) begin
            if (ones != 4'd0) begin
                ones_next = ones - 4'd1;
            end else if (tens != 4'd0) begin
                ones_next = 4'd9;
                tens_next = tens - 4'd1;
            end
        end
`endif
    end

    // A hit is checked before the timeout, so a hit on the last FIRE cycle scores.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            timer <= '0;
            laser <= 1'b0;
            tens  <= 4'd0;
            ones  <= 4'd0;
        end else begin
            tens <= tens_next;
            ones <= ones_next;
            case (state)
                ST_IDLE: begin
                    if (trig_rise) begin
                        state <= ST_FIRE;
                        laser <= 1'b1;
                        timer <= '0;
                    end
                end
                ST_FIRE: begin
                    if (hit || miss) begin
                        state <= ST_COOLDOWN;
                        laser <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (timer == COOL_LAST) begin
                        state <= ST_REARM;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_REARM: begin
                    if (!flex_deb) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    laser <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/laser_target_core.sv
// Two-player laser-target game: shared LFSR, hit-driven retargeting and score display.
// Build macro MISS_PENALTY_EN enables score decrement on a missed shot.
module laser_target_core
    import laser_game_pkg::*;
#(
    parameter int NUM_SENSORS     = 10,
    parameter int TARGET_W        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SHOT_CYCLES     = 64,
    parameter int COOLDOWN_CYCLES = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flex_r,
    input  logic                   flex_l,
    input  logic [NUM_SENSORS-1:0] photo_array,
    output logic                   laser_r,
    output logic                   laser_l,
    output logic [TARGET_W-1:0]    target_a,
    output logic [TARGET_W-1:0]    target_b,
    output logic [6:0]             score_digit_a,
    output logic [6:0]             score_digit_b,
    output logic [6:0]             score_digit_c,
    output logic [6:0]             score_digit_d
);

    localparam int SUM_W = TARGET_W + 2;
    localparam logic [SUM_W-1:0] NS = SUM_W'(NUM_SENSORS);

    logic [NUM_SENSORS-1:0] photo_p0;
    logic [NUM_SENSORS-1:0] photo_p1;
    logic [7:0]             lfsr;
    logic                   hit_a;
    logic                   hit_b;
    logic [3:0]             tens_a_next;
    logic [3:0]             ones_a_next;
    logic [3:0]             tens_b_next;
    logic [3:0]             ones_b_next;
    logic [TARGET_W-1:0]    new_target_a;
    logic [TARGET_W-1:0]    new_target_b;

    // Sum never exceeds NUM_SENSORS+3, so two conditional subtractions reduce
    // it mod NUM_SENSORS for any legal sensor count (>= 3).
    function automatic logic [SUM_W-1:0] wrap_index(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] r;
        r = s;
        if (r >= NS) r = r - NS;
        if (r >= NS) r = r - NS;
        return r;
    endfunction

    function automatic logic [TARGET_W-1:0] retarget(
        input logic [TARGET_W-1:0] cur,
        input logic [1:0]          step,
        input logic [TARGET_W-1:0] other
    );
        logic [SUM_W-1:0] s;
        s = wrap_index({2'b00, cur} + SUM_W'(step) + SUM_W'(1));
        if (s[TARGET_W-1:0] == other) begin
            s = wrap_index(s + SUM_W'(1));
        end
        return s[TARGET_W-1:0];
    endfunction

    laser_player #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SHOT_CYCLES     (SHOT_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
    ) u_player_a (
        .clock     (clock),
        .reset     (reset),
        .flex      (flex_r),
        .photo_hit (photo_p1[target_a]),
        .laser     (laser_r),
        .hit       (hit_a),
        .tens_next (tens_a_next),
        .ones_next (ones_a_next)
    );

    laser_player #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SHOT_CYCLES     (SHOT_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
    ) u_player_b (
        .clock     (clock),
        .reset     (reset),
        .flex      (flex_l),
        .photo_hit (photo_p1[target_b]),
        .laser     (laser_l),
        .hit       (hit_b),
        .tens_next (tens_b_next),
        .ones_next (ones_b_next)
    );

    // On simultaneous hits A moves first, and B steers around A's new target.
    always_comb begin
        new_target_a = target_a;
        new_target_b = target_b;
        if (hit_a) new_target_a = retarget(target_a, lfsr[1:0], target_b);
        if (hit_b) new_target_b = retarget(target_b, lfsr[1:0], new_target_a);
    end

    // Stage p0/p1: photodiode synchroniser; displays encode next-score so the
    // digits change on the same edge as the score itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            photo_p0      <= '0;
            photo_p1      <= '0;
            lfsr          <= LFSR_SEED;
            target_a      <= TARGET_W'(NUM_SENSORS - 1);
            target_b      <= '0;
            score_digit_a <= seg_encode(4'd0);
            score_digit_b <= seg_encode(4'd0);
            score_digit_c <= seg_encode(4'd0);
            score_digit_d <= seg_encode(4'd0);
        end else begin
            photo_p0      <= photo_array;
            photo_p1      <= photo_p0;
            lfsr          <= lfsr_step(lfsr);
            target_a      <= new_target_a;
            target_b      <= new_target_b;
            score_digit_a <= seg_encode(tens_a_next);
            score_digit_b <= seg_encode(ones_a_next);
            score_digit_c <= seg_encode(tens_b_next);
            score_digit_d <= seg_encode(ones_b_next);
        end
    end

endmodule

// File: tb/tb_laser_target_core.sv
// Randomised self-checking bench for laser_target_core against a score/target model.
// Honours MISS_PENALTY_EN in its expected miss scoring.
module tb_laser_target_core;

    localparam int N    = 10;
    localparam int TW   = 4;
    localparam int SHOT = 64;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    logic          clock = 1'b0;
    logic          reset;
    logic          flex_r;
    logic          flex_l;
    logic [N-1:0]  photo_array;
    logic          laser_r;
    logic          laser_l;
    logic [TW-1:0] target_a;
    logic [TW-1:0] target_b;
    logic [6:0]    score_digit_a;
    logic [6:0]    score_digit_b;
    logic [6:0]    score_digit_c;
    logic [6:0]    score_digit_d;
    logic [27:0]   digits;

    int tests = 0;
    int fails = 0;
    int m_score [2];
    int m_tgt [2];
    logic [7:0] m_lfsr;

    always #5 clock = ~clock;

    laser_target_core #(
        .NUM_SENSORS     (N),
        .TARGET_W        (TW),
        .DEBOUNCE_CYCLES (16),
        .SHOT_CYCLES     (SHOT),
        .COOLDOWN_CYCLES (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flex_r        (flex_r),
        .flex_l        (flex_l),
        .photo_array   (photo_array),
        .laser_r       (laser_r),
        .laser_l       (laser_l),
        .target_a      (target_a),
        .target_b      (target_b),
        .score_digit_a (score_digit_a),
        .score_digit_b (score_digit_b),
        .score_digit_c (score_digit_c),
        .score_digit_d (score_digit_d)
    );

    assign digits = {score_digit_a, score_digit_b, score_digit_c, score_digit_d};

    // Free-running x^8+x^6+x^5+x^4+1 sequence from seed A5.
    always @(posedge clock) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic las(input int pb);
        return (pb == 0) ? laser_r : laser_l;
    endfunction

    function automatic int next_target(input int cur, input int step, input int other);
        int n;
        n = (cur + 1 + step) % N;
        if (n == other) n = (n + 1) % N;
        return n;
    endfunction

    // Photo raised d cycles into FIRE is seen 3 edges later, unless the window closes first.
    function automatic int exp_drop(input int d);
        return (d >= 0 && d <= SHOT - 3) ? d + 3 : SHOT;
    endfunction

    function automatic logic [27:0] exp_digits();
        return {SEG[m_score[0] / 10], SEG[m_score[0] % 10], SEG[m_score[1] / 10], SEG[m_score[1] % 10]};
    endfunction

    function automatic void apply_shot(input int pb, input bit was_hit, input logic [7:0] lf);
        if (was_hit) begin
            if (m_score[pb] < 99) m_score[pb]++;
            m_tgt[pb] = next_target(m_tgt[pb], int'(lf[1:0]), m_tgt[1 - pb]);
        end
`ifdef MISS_PENALTY_EN
        else if (m_score[pb] > 0) begin
            m_score[pb]--;
        end
`endif
    endfunction

    function automatic void model_reset();
        m_score[0] = 0;
        m_score[1] = 0;
        m_tgt[0]   = N - 1;
        m_tgt[1]   = 0;
    endfunction

    // Press, wait for the laser, light the target d cycles into FIRE (d<0: never),
    // and report rise latency, FIRE length and the LFSR value used on the final edge.
    task automatic fire_shot(input int pb, input int d, input bit hold,
                             output int rise_n, output int drop_t, output logic [7:0] lf_used);
        logic [N-1:0] noise;
        if (pb == 0) flex_r = 1'b1;
        else         flex_l = 1'b1;
        rise_n = 0;
        while (rise_n < 40 && !las(pb)) begin
            @(negedge clock);
            rise_n++;
        end
        noise = N'($urandom) & ~(N'(1) << m_tgt[pb]);
        photo_array = noise;
        drop_t = 0;
        lf_used = m_lfsr;
        do begin
            if (drop_t == d) photo_array[m_tgt[pb]] = 1'b1;
            lf_used = m_lfsr;
            @(negedge clock);
            drop_t++;
        end while (drop_t < 80 && las(pb));
        photo_array = '0;
        if (!hold) begin
            if (pb == 0) flex_r = 1'b0;
            else         flex_l = 1'b0;
            repeat (45) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flex_r = 1'b0;
        flex_l = 1'b0;
        photo_array = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tests++;
        if (target_a !== TW'(9) || target_b !== TW'(0)) begin
            fails++;
            $display("FAIL reset_targets: got %0d/%0d, expected 9/0", target_a, target_b);
        end
        tests++;
        if (digits !== {4{7'b1000000}}) begin
            fails++;
            $display("FAIL reset_digits: got %h, expected %h", digits, {4{7'b1000000}});
        end
        tests++;
        if (laser_r !== 1'b0 || laser_l !== 1'b0) begin
            fails++;
            $display("FAIL reset_lasers: got %b%b, expected 00", laser_r, laser_l);
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_single_hit();
        int r, dt, d;
        logic [7:0] lf;
        d = int'($urandom_range(0, 20));
        fire_shot(0, d, 1'b0, r, dt, lf);
        apply_shot(0, 1'b1, lf);
        tests++;
        if (r != 19) begin
            fails++;
            $display("FAIL hit_rise_latency: got %0d cycles, expected 19", r);
        end
        tests++;
        if (dt != d + 3) begin
            fails++;
            $display("FAIL hit_drop: got %0d, expected %0d", dt, d + 3);
        end
        tests++;
        if (digits !== exp_digits() || score_digit_b !== SEG[1]) begin
            fails++;
            $display("FAIL hit_score: got %h, expected %h", digits, exp_digits());
        end
        tests++;
        if (target_a === TW'(9) || target_a === target_b || target_a !== TW'(m_tgt[0])) begin
            fails++;
            $display("FAIL hit_retarget: got %0d (b=%0d), expected %0d", target_a, target_b, m_tgt[0]);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 4; k++) begin
            int g;
            bit seen;
            g = (k == 0) ? 15 : int'($urandom_range(1, 15));
            seen = 1'b0;
            flex_r = 1'b1;
            repeat (g) begin
                @(negedge clock);
                if (laser_r) seen = 1'b1;
            end
            flex_r = 1'b0;
            repeat (40) begin
                @(negedge clock);
                if (laser_r) seen = 1'b1;
            end
            tests++;
            if (seen) begin
                fails++;
                $display("FAIL glitch_%0d: laser fired on a %0d-cycle pulse, expected none", k, g);
            end
        end
    endtask

    task automatic test_miss();
        int r, dt;
        logic [7:0] lf;
        fire_shot(1, -1, 1'b0, r, dt, lf);
        apply_shot(1, 1'b0, lf);
        tests++;
        if (r != 19 || dt != SHOT) begin
            fails++;
            $display("FAIL miss_b_window: got rise %0d high %0d, expected 19/%0d", r, dt, SHOT);
        end
        tests++;
        if (digits !== exp_digits()) begin
            fails++;
            $display("FAIL miss_b_score: got %h, expected %h", digits, exp_digits());
        end
        while (m_score[0] < 5) begin
            fire_shot(0, int'($urandom_range(0, 30)), 1'b0, r, dt, lf);
            apply_shot(0, 1'b1, lf);
        end
        tests++;
        if (digits !== exp_digits() || {target_a, target_b} !== {TW'(m_tgt[0]), TW'(m_tgt[1])}) begin
            fails++;
            $display("FAIL miss_preload: got %h t=%0d/%0d, expected %h t=%0d/%0d",
                     digits, target_a, target_b, exp_digits(), m_tgt[0], m_tgt[1]);
        end
        fire_shot(0, -1, 1'b0, r, dt, lf);
        apply_shot(0, 1'b0, lf);
        tests++;
        if (dt != SHOT) begin
            fails++;
            $display("FAIL miss_a_window: got %0d cycles, expected %0d", dt, SHOT);
        end
        tests++;
        if (digits !== exp_digits() || {target_a, target_b} !== {TW'(m_tgt[0]), TW'(m_tgt[1])}) begin
            fails++;
            $display("FAIL miss_a_score: got %h t=%0d, expected %h t=%0d", digits, target_a, exp_digits(), m_tgt[0]);
        end
    endtask

    task automatic test_final_cycle();
        int delays [3] = '{SHOT - 4, SHOT - 3, SHOT - 2};
        foreach (delays[i]) begin
            int r, dt;
            logic [7:0] lf;
            fire_shot(0, delays[i], 1'b0, r, dt, lf);
            apply_shot(0, delays[i] <= SHOT - 3, lf);
            tests++;
            if (dt != exp_drop(delays[i])) begin
                fails++;
                $display("FAIL edge_drop_d%0d: got %0d, expected %0d", delays[i], dt, exp_drop(delays[i]));
            end
            tests++;
            if (digits !== exp_digits() || target_a !== TW'(m_tgt[0])) begin
                fails++;
                $display("FAIL edge_score_d%0d: got %h t=%0d, expected %h t=%0d",
                         delays[i], digits, target_a, exp_digits(), m_tgt[0]);
            end
        end
    endtask

    task automatic test_random_shots();
        for (int k = 0; k < 8; k++) begin
            int pb, d, r, dt;
            logic [7:0] lf;
            pb = int'($urandom_range(0, 1));
            d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 66));
            fire_shot(pb, d, 1'b0, r, dt, lf);
            apply_shot(pb, d >= 0 && d <= SHOT - 3, lf);
            tests++;
            if (r != 19 || dt != exp_drop(d)) begin
                fails++;
                $display("FAIL rand_%0d_timing: got rise %0d drop %0d, expected 19/%0d", k, r, dt, exp_drop(d));
            end
            tests++;
            if (digits !== exp_digits() || {target_a, target_b} !== {TW'(m_tgt[0]), TW'(m_tgt[1])}) begin
                fails++;
                $display("FAIL rand_%0d_state: got %h t=%0d/%0d, expected %h t=%0d/%0d",
                         k, digits, target_a, target_b, exp_digits(), m_tgt[0], m_tgt[1]);
            end
        end
    endtask

    task automatic test_hold_through_cooldown();
        int r, dt;
        bit seen;
        logic [7:0] lf;
        fire_shot(0, 5, 1'b1, r, dt, lf);
        apply_shot(0, 1'b1, lf);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clock);
            if (laser_r) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL hold_refire: laser rose while trigger held, expected 0");
        end
        flex_r = 1'b0;
        repeat (45) @(negedge clock);
        fire_shot(0, -1, 1'b0, r, dt, lf);
        apply_shot(0, 1'b0, lf);
        tests++;
        if (r != 19 || dt != SHOT) begin
            fail_line: begin
                fails++;
                $display("FAIL hold_repress: got rise %0d high %0d, expected 19/%0d", r, dt, SHOT);
            end
        end
        tests++;
        if (digits !== exp_digits() || target_a !== TW'(m_tgt[0])) begin
            fails++;
            $display("FAIL hold_state: got %h t=%0d, expected %h t=%0d", digits, target_a, exp_digits(), m_tgt[0]);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 3; k++) begin
            int n, t, d;
            logic [7:0] lf;
            d = int'($urandom_range(0, 40));
            flex_r = 1'b1;
            flex_l = 1'b1;
            n = 0;
            while (n < 40 && !(laser_r && laser_l)) begin
                @(negedge clock);
                n++;
            end
            tests++;
            if (n != 19) begin
                fails++;
                $display("FAIL sim_%0d_rise: got %0d, expected 19", k, n);
            end
            t = 0;
            lf = m_lfsr;
            do begin
                if (t == d) begin
                    photo_array[m_tgt[0]] = 1'b1;
                    photo_array[m_tgt[1]] = 1'b1;
                end
                lf = m_lfsr;
                @(negedge clock);
                t++;
            end while (t < 80 && (laser_r || laser_l));
            apply_shot(0, 1'b1, lf);
            apply_shot(1, 1'b1, lf);
            tests++;
            if (t != d + 3) begin
                fails++;
                $display("FAIL sim_%0d_drop: got %0d, expected %0d", k, t, d + 3);
            end
            tests++;
            if (digits !== exp_digits() || target_a === target_b ||
                {target_a, target_b} !== {TW'(m_tgt[0]), TW'(m_tgt[1])}) begin
                fails++;
                $display("FAIL sim_%0d_state: got %h t=%0d/%0d, expected %h t=%0d/%0d",
                         k, digits, target_a, target_b, exp_digits(), m_tgt[0], m_tgt[1]);
            end
            photo_array = '0;
            flex_r = 1'b0;
            flex_l = 1'b0;
            repeat (45) @(negedge clock);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 100; k++) begin
            int r, dt;
            logic [7:0] lf;
            fire_shot(0, int'($urandom_range(0, 10)), 1'b0, r, dt, lf);
            apply_shot(0, 1'b1, lf);
            tests++;
            if (digits !== exp_digits() || {target_a, target_b} !== {TW'(m_tgt[0]), TW'(m_tgt[1])}) begin
                fails++;
                $display("FAIL sat_%0d: got %h t=%0d/%0d, expected %h t=%0d/%0d",
                         k, digits, target_a, target_b, exp_digits(), m_tgt[0], m_tgt[1]);
            end
        end
        tests++;
        if (score_digit_a !== SEG[9] || score_digit_b !== SEG[9]) begin
            fails++;
            $display("FAIL sat_99: got %h %h, expected %h %h", score_digit_a, score_digit_b, SEG[9], SEG[9]);
        end
    endtask

    task automatic test_reset_mid_shot();
        int n, r, dt;
        logic [7:0] lf;
        flex_l = 1'b1;
        n = 0;
        while (n < 40 && !laser_l) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        flex_l = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        tests++;
        if (laser_l !== 1'b0 || laser_r !== 1'b0) begin
            fails++;
            $display("FAIL midrst_lasers: got %b%b, expected 00", laser_r, laser_l);
        end
        tests++;
        if (target_a !== TW'(9) || target_b !== TW'(0) || digits !== {4{7'b1000000}}) begin
            fails++;
            $display("FAIL midrst_state: got t=%0d/%0d %h, expected 9/0 %h",
                     target_a, target_b, digits, {4{7'b1000000}});
        end
        repeat (5) @(negedge clock);
        fire_shot(0, 2, 1'b0, r, dt, lf);
        apply_shot(0, 1'b1, lf);
        tests++;
        if (r != 19 || digits !== exp_digits() || target_a !== TW'(m_tgt[0])) begin
            fails++;
            $display("FAIL midrst_after: got rise %0d %h t=%0d, expected 19 %h t=%0d",
                     r, digits, target_a, exp_digits(), m_tgt[0]);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_glitch();
        test_miss();
        test_final_cycle();
        test_random_shots();
        test_hold_through_cooldown();
        test_simultaneous();
        test_saturation();
        test_reset_mid_shot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
